// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave loopback: each received word is echoed back in the next word slot.
// Pins are synchronized to clk (2 flops) and edges act one clk later; miso and rx_valid lag pin edges by 3-4 clk.
module spi_slave_core #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_TX   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [1:0]            cs_sync_q;
  logic [2:0]            sck_sync_q;
  logic [1:0]            mosi_sync_q;

  logic [0:0]            state_q,    state_d;
  logic [CW-1:0]         bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q,   tx_buf_d;
  logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q,     miso_d;

  logic                  cs_s, mosi_s, sck_rise, sck_fall;
  logic [DATA_WIDTH-1:0] rx_word;

  // Synchronizers reset to the bus idle levels so release from reset never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], cs};
      sck_sync_q  <= {sck_sync_q[1:0], sck};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];
  assign rx_word  = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    miso_d     = miso_q;

    if (state_q == ST_IDLE) begin
      if (!cs_s) begin
        state_d    = ST_ACTIVE;
        bit_cnt_d  = '0;
        tx_shift_d = tx_buf_q;
        miso_d     = tx_buf_q[DATA_WIDTH-1];
      end
    end else begin
      // cs deassertion takes priority over a coincident sck edge; a partial word is dropped.
      if (cs_s) begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        miso_d    = 1'b0;
      end else if (sck_rise) begin
        rx_shift_d = rx_word;
        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
          bit_cnt_d  = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          tx_buf_d   = rx_word;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end else if (sck_fall) begin
        if (bit_cnt_q == '0) begin
          tx_shift_d = tx_buf_q;
          miso_d     = tx_buf_q[DATA_WIDTH-1];
        end else begin
          tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          miso_d     = tx_shift_q[DATA_WIDTH-2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= RESET_TX;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: an SPI master model drives frames at sck = clk/20 and
// checks miso, rx_data and rx_valid against an echo-buffer reference model.
module tb_spi_slave_core;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;

  int n_chk;
  int n_fail;
  int vld_cnt;

  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];

  // reference model state
  logic [7:0] exp_tx;
  logic [7:0] exp_rx;

  spi_slave_core #(.DATA_WIDTH(8), .RESET_TX(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) vld_cnt <= vld_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master: cs low, then per bit drive mosi, sample miso just before the sck rise.
  task automatic run_frame(input int nbytes, input int abort_bits);
    int total;
    total = (abort_bits > 0) ? abort_bits : nbytes * 8;
    cs = 1'b0;
    wait_clk(10);
    for (int b = 0; b < total; b++) begin
      mosi = m_tx[b / 8][7 - (b % 8)];
      wait_clk(10);
      m_rx[b / 8][7 - (b % 8)] = miso;
      sck = 1'b1;
      wait_clk(10);
      sck = 1'b0;
    end
    wait_clk(10);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
  endtask

  task automatic frame_and_check(input string tag, input int nbytes, input int abort_bits);
    int v0;
    int exp_pulses;
    v0 = vld_cnt;
    run_frame(nbytes, abort_bits);
    exp_pulses = (abort_bits > 0) ? 0 : nbytes;
    if (abort_bits == 0) begin
      for (int i = 0; i < nbytes; i++) begin
        check({tag, "_miso"}, 32'(m_rx[i]), 32'(exp_tx));
        exp_tx = m_tx[i];
        exp_rx = m_tx[i];
      end
    end
    check({tag, "_vld"}, 32'(vld_cnt - v0), 32'(exp_pulses));
    check({tag, "_rxd"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_idle_miso"}, 32'(miso), 32'h0);
  endtask

  initial begin
    int nb;
    n_chk   = 0;
    n_fail  = 0;
    vld_cnt = 0;
    rst  = 1'b0;
    cs   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    exp_tx = 8'hA5;
    exp_rx = 8'h00;

    // reset held, then released; outputs stay at reset values throughout
    for (int c = 0; c < 15; c++) begin
      if (c == 5) rst = 1'b1;
      wait_clk(1);
      check("rst_miso", 32'(miso), 32'h0);
      check("rst_rxd", 32'(rx_data), 32'h0);
      check("rst_vld", 32'(rx_valid), 32'h0);
    end

    m_tx[0] = 8'h3C;
    frame_and_check("single", 1, 0);

    m_tx[0] = 8'h00;
    frame_and_check("echo", 1, 0);

    m_tx[0] = 8'h11;
    m_tx[1] = 8'h22;
    frame_and_check("two", 2, 0);

    m_tx[0] = 8'hFF;
    frame_and_check("abort", 1, 5);

    m_tx[0] = 8'h5A;
    frame_and_check("post_abort", 1, 0);

    // reset pulse after 3 bits of a frame
    cs = 1'b0;
    m_tx[0] = 8'hC3;
    wait_clk(10);
    for (int b = 0; b < 3; b++) begin
      mosi = m_tx[0][7 - b];
      wait_clk(10);
      sck = 1'b1;
      wait_clk(10);
      sck = 1'b0;
    end
    wait_clk(5);
    rst = 1'b0;
    wait_clk(2);
    check("midrst_miso", 32'(miso), 32'h0);
    check("midrst_rxd", 32'(rx_data), 32'h0);
    check("midrst_vld", 32'(rx_valid), 32'h0);
    cs   = 1'b1;
    mosi = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(10);
    exp_tx = 8'hA5;
    exp_rx = 8'h00;
    check("midrst_after_rxd", 32'(rx_data), 32'h0);
    m_tx[0] = 8'h96;
    frame_and_check("after_rst", 1, 0);

    // randomized frames: 1..4 bytes, occasional aborts of 1..7 bits
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(4, 1);
      for (int i = 0; i < 4; i++) m_tx[i] = 8'($urandom);
      if ($urandom_range(5, 0) == 0)
        frame_and_check("rnd_abort", 1, $urandom_range(7, 1));
      else
        frame_and_check("rnd", nb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

Byte-oriented SPI slave (mode 0, MSB first) that synchronizes the external SPI pins into the system clock domain. It deserializes MOSI into a parallel byte and serializes a transmit byte onto MISO. Each received byte is echoed back as the transmit data of the following byte slot, so the block runs as a self-contained loopback endpoint with no parallel host interface. It sits at the chip boundary behind the SPI pads.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI word.
- `RESET_TX`, default 8'hA5: transmit word used for the first slot after reset.
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset (0 = reset).
- `cs`, input, 1: chip select, active low, asynchronous to `clk`.
- `sck`, input, 1: SPI serial clock, idles low (CPOL=0), asynchronous to `clk`.
- `mosi`, input, 1: master-out data.
- `miso`, output, 1: slave-out data. Driven 0 when deselected; there is no tristate.
- `rx_data`, output, DATA_WIDTH: last complete received word.
- `rx_valid`, output, 1: one-`clk` pulse when `rx_data` updates.

## Operation
- **Synchronization:**
  - `cs`, `sck` and `mosi` each pass through a 2-flop synchronizer.
  - A third `sck` flop provides edge detection.
  - All three inputs see equal delay, so `mosi` stays aligned with `sck`.
- **States:**
  - IDLE: synced `cs`=1.
  - ACTIVE: synced `cs`=0.
- **IDLE → ACTIVE (falling edge of synced `cs`):**
  - `bit_cnt` ← 0.
  - Shift register ← `tx_buf`.
  - `miso` ← MSB of `tx_buf`.
- **In ACTIVE, rising edge of synced `sck`:**
  - The synced `mosi` bit shifts into the receive register at the LSB (MSB arrives first).
  - `bit_cnt` increments.
- **Word completion:** when `bit_cnt` wraps from DATA_WIDTH-1 to 0:
  - `rx_data` ← the assembled word.
  - `rx_valid` = 1 for exactly one cycle.
  - `tx_buf` ← the assembled word (echo).
- **In ACTIVE, falling edge of synced `sck`:**
  - If `bit_cnt` = 0 (word boundary), reload the shift register from `tx_buf` and present its MSB.
  - Otherwise shift left and present the next bit.
  - Back-to-back words within one frame: word n+1 transmits word n.
- **ACTIVE → IDLE (rising edge of synced `cs`):**
  - Go to IDLE and clear `bit_cnt`.
  - A partial word is discarded: no `rx_valid`, and `rx_data` and `tx_buf` are unchanged.
  - `miso` ← 0.
- **Edges in IDLE:** `sck` edges while in IDLE are ignored.
- **Reset values:**
  - `miso` = 0, `rx_data` = 0, `rx_valid` = 0.
  - `bit_cnt` = 0, shift registers = 0, `tx_buf` = RESET_TX.
  - Synchronizers = idle levels: `cs`=1, `sck`=0, `mosi`=0.
  - State = IDLE.
- **Reset mid-transfer:** aborts immediately. The master must deassert and reassert `cs` before starting a new frame.

## Timing
- **Input latency:** 2 `clk` from a pin change to its synced value; an edge is acted on 1 `clk` later (3 total).
- **`miso` validity:**
  - Valid 3–4 `clk` after the `cs` falling pin edge.
  - Valid 3–4 `clk` after each `sck` falling pin edge.
- **SCK limits:** each `sck` high and low phase must be ≥ 4 `clk` periods, so `sck` ≤ f_clk/8.
- **`cs` setup/hold:** ≥ 4 `clk` between `cs` falling and the first `sck` rising, and between the last `sck` falling and `cs` rising.
- **`rx_valid`:** asserts 3–4 `clk` after the DATA_WIDTH-th `sck` rising pin edge.
- **Simultaneous events:** if the synced `cs` deassertion coincides with an `sck` edge, `cs` wins and the edge is ignored.

## Test plan
- **Reset:**
  - Stimulus: assert `rst`=0 with `cs`=1 and `sck`=0, then release.
  - Required: `miso`=0, `rx_data`=0, `rx_valid`=0 throughout.
- **Single byte (`sck` = clk/20):**
  - Stimulus: frame shifting 0x3C on `mosi`.
  - Required: the master samples 0xA5 on `miso`; `rx_valid` pulses once; `rx_data`=0x3C.
- **Echo across frames:**
  - Stimulus: next frame sends 0x00.
  - Required: `miso` returns 0x3C; `rx_data`=0x00.
- **Two bytes in one frame:**
  - Stimulus: send 0x11 then 0x22 with `cs` held low.
  - Required: `miso` returns the previous `tx_buf` then 0x11; two `rx_valid` pulses; `rx_data`=0x22.
- **Abort:**
  - Stimulus: raise `cs` after 5 bits of 0xFF.
  - Required: no `rx_valid`; `rx_data` unchanged; the next full frame receives correctly starting from bit 7.
- **Reset mid-frame:**
  - Stimulus: pulse `rst` low after 3 bits.
  - Required: all outputs return to reset values and `tx_buf`=0xA5; a subsequent frame transmits 0xA5.
